// File: rtl/mem_pkg.sv
// Shared MemOp encodings, FSM states and lane helpers for the memory-stage access unit.
package mem_pkg;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_HS = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_BS = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_WU = 3'b101;
  localparam logic [2:0] OP_D  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_t;

  // Offset bits that must be zero for a naturally aligned access of this op.
  function automatic logic [2:0] align_mask(input logic [2:0] op);
    case (op)
      OP_BS, OP_BU: align_mask = 3'b000;
      OP_HS, OP_HU: align_mask = 3'b001;
      OP_D:         align_mask = 3'b111;
      default:      align_mask = 3'b011;
    endcase
  endfunction

  // Byte enables for up to 8 lanes; callers truncate to their lane count.
  function automatic logic [7:0] be_mask(input logic [2:0] op, input logic [2:0] off);
    case (op)
      OP_BS, OP_BU: be_mask = 8'h01 << off;
      OP_HS, OP_HU: be_mask = 8'h03 << off;
      OP_D:         be_mask = 8'hFF;
      default:      be_mask = 8'h0F << {off[2], 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-memory bus signals of the access unit.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [NB-1:0]     mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_exc;
  logic [ADDR_W-1:0] resp_badaddr;

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           resp_valid, resp_data, resp_exc, resp_badaddr
  );

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           resp_valid, resp_data, resp_exc, resp_badaddr
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Extracts the addressed lane from a bus read word and sign/zero-extends it per MemOp.
module load_extend
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = 2
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [2:0]        i_op,
  output logic [DATA_W-1:0] o_data
);
  logic [DATA_W-1:0] w_sh;

  assign w_sh = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = '0;
    case (i_op)
      OP_BS:   o_data = DATA_W'($signed(w_sh[7:0]));
      OP_BU:   o_data = DATA_W'(w_sh[7:0]);
      OP_HS:   o_data = DATA_W'($signed(w_sh[15:0]));
      OP_HU:   o_data = DATA_W'(w_sh[15:0]);
      OP_WU:   o_data = DATA_W'(w_sh[31:0]);
      OP_D:    o_data = w_sh;
      default: o_data = DATA_W'($signed(w_sh[31:0]));
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine driving a req/ack data bus with byte enables and lane replication.
// Optional alignment exception via MEM_ALIGN_CHK_EN; otherwise low offset bits are forced to zero.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic         clk,
  input logic         reset_n,
  mem_access_unit_if.slave bus
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  state_t            r_state, w_next;
  logic [2:0]        w_op;
  logic [OFF_W-1:0]  w_lowmask, w_off;
  logic              w_misalign;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wdata, w_ext;
  logic              w_accept, w_ack;

  logic              r_we;
  logic [2:0]        r_op;
  logic [OFF_W-1:0]  r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [NB-1:0]     r_be;
  logic [DATA_W-1:0] r_wdata, r_resp_data;
`ifdef MEM_ALIGN_CHK_EN
  logic              r_exc;
  logic [ADDR_W-1:0] r_badaddr;
`endif

  // Ops the bus width cannot carry fall back to signed word.
  always_comb begin
    w_op = bus.req_op;
    if (DATA_W == 32) begin
      if (bus.req_op inside {OP_WU, OP_D, 3'b111}) w_op = OP_W;
    end else if (bus.req_op == 3'b111) begin
      w_op = OP_W;
    end
  end

  assign w_lowmask = OFF_W'(align_mask(w_op));
  assign w_off     = bus.req_addr[OFF_W-1:0] & ~w_lowmask;
  assign w_be      = NB'(be_mask(w_op, 3'(w_off)));
`ifdef MEM_ALIGN_CHK_EN
  assign w_misalign = |(bus.req_addr[OFF_W-1:0] & w_lowmask);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    case (w_op)
      OP_BS, OP_BU: w_wdata = {NB{bus.req_wdata[7:0]}};
      OP_HS, OP_HU: w_wdata = {(NB/2){bus.req_wdata[15:0]}};
      OP_D:         w_wdata = bus.req_wdata;
      default:      w_wdata = {(NB/4){bus.req_wdata[31:0]}};
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;
  assign w_ack    = (r_state == ST_BUS) && bus.mem_ack;

  load_extend #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_load_extend (
    .i_rdata (bus.mem_rdata),
    .i_off   (r_off),
    .i_op    (r_op),
    .o_data  (w_ext)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.req_valid) w_next = w_misalign ? ST_RESP : ST_BUS;
      ST_BUS:  if (bus.mem_ack) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (r_state == ST_IDLE);
    bus.mem_req    = (r_state == ST_BUS);
    bus.mem_we     = (r_state == ST_BUS) && r_we;
    bus.resp_valid = (r_state == ST_RESP);
    bus.resp_exc   = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
    bus.resp_exc   = (r_state == ST_RESP) && r_exc;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_we        <= 1'b0;
      r_op        <= OP_W;
      r_off       <= '0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_resp_data <= '0;
`ifdef MEM_ALIGN_CHK_EN
      r_exc       <= 1'b0;
      r_badaddr   <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_we        <= bus.req_we;
        r_op        <= w_op;
        r_off       <= w_off;
        r_addr      <= bus.req_addr & ~ADDR_W'(NB - 1);
        r_be        <= w_be;
        r_wdata     <= w_wdata;
        r_resp_data <= '0;
`ifdef MEM_ALIGN_CHK_EN
        r_exc       <= w_misalign;
        r_badaddr   <= w_misalign ? bus.req_addr : '0;
`endif
      end
      if (w_ack && !r_we) r_resp_data <= w_ext;
    end
  end

  assign bus.mem_be    = r_be;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.resp_data = r_resp_data;
`ifdef MEM_ALIGN_CHK_EN
  assign bus.resp_badaddr = r_badaddr;
`else
  assign bus.resp_badaddr = '0;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: 32- and 64-bit instances against a byte-level reference model.
`timescale 1ns/1ps

module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_asserts = 0;
  int   n_fail = 0;
  bit   sel64 = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) if32 ();
  mem_access_unit_if #(.ADDR_W(32), .DATA_W(64)) if64 ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) u32 (.clk(clk), .reset_n(reset_n), .bus(if32.slave));
  mem_access_unit #(.ADDR_W(32), .DATA_W(64)) u64 (.clk(clk), .reset_n(reset_n), .bus(if64.slave));

  logic        o_req_ready, o_mem_req, o_mem_we, o_resp_valid, o_resp_exc;
  logic [7:0]  o_mem_be;
  logic [31:0] o_mem_addr, o_resp_badaddr;
  logic [63:0] o_mem_wdata, o_resp_data;

  assign o_req_ready    = sel64 ? if64.req_ready    : if32.req_ready;
  assign o_mem_req      = sel64 ? if64.mem_req      : if32.mem_req;
  assign o_mem_we       = sel64 ? if64.mem_we       : if32.mem_we;
  assign o_resp_valid   = sel64 ? if64.resp_valid   : if32.resp_valid;
  assign o_resp_exc     = sel64 ? if64.resp_exc     : if32.resp_exc;
  assign o_mem_be       = sel64 ? if64.mem_be       : {4'h0, if32.mem_be};
  assign o_mem_addr     = sel64 ? if64.mem_addr     : if32.mem_addr;
  assign o_resp_badaddr = sel64 ? if64.resp_badaddr : if32.resp_badaddr;
  assign o_mem_wdata    = sel64 ? if64.mem_wdata    : {32'h0, if32.mem_wdata};
  assign o_resp_data    = sel64 ? if64.resp_data    : {32'h0, if32.resp_data};

  task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_fail++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: access size in bytes, natural alignment, little-endian byte gather/scatter.
  task automatic model(input bit w64, input bit we, input logic [2:0] op_in,
                       input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                       output bit exc, output logic [31:0] ea, output logic [7:0] ebe,
                       output logic [63:0] ewd, output logic [63:0] ed);
    int unsigned nb, n, off;
    bit sgn;
    logic [2:0] op;
    nb = w64 ? 8 : 4;
    op = op_in;
    if (op == 3'd7 || (!w64 && op >= 3'd5)) op = 3'd0;
    case (op)
      3'd0: begin n = 4; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: begin n = 2; sgn = 0; end
      3'd3: begin n = 1; sgn = 1; end
      3'd4: begin n = 1; sgn = 0; end
      3'd5: begin n = 4; sgn = 0; end
      default: begin n = 8; sgn = 0; end
    endcase
    off = addr % nb;
`ifdef MEM_ALIGN_CHK_EN
    exc = (off % n) != 0;
`else
    exc = 1'b0;
    off = off - (off % n);
`endif
    ea  = addr - (addr % nb);
    ebe = 8'(((1 << n) - 1) << off);
    ewd = '0;
    for (int i = 0; i < int'(nb); i++) ewd[i*8 +: 8] = wd[(i % n)*8 +: 8];
    ed = '0;
    if (!we && !exc) begin
      for (int i = 0; i < int'(n); i++) ed[i*8 +: 8] = rd[(off + i)*8 +: 8];
      if (sgn && ed[8*n - 1])
        for (int i = int'(n); i < int'(nb); i++) ed[i*8 +: 8] = 8'hFF;
    end
  endtask

  task automatic set_req(input bit v, input bit we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [63:0] wd);
    if (sel64) begin
      if64.req_valid = v; if64.req_we = we; if64.req_op = op;
      if64.req_addr = addr; if64.req_wdata = wd;
    end else begin
      if32.req_valid = v; if32.req_we = we; if32.req_op = op;
      if32.req_addr = addr; if32.req_wdata = wd[31:0];
    end
  endtask

  task automatic set_ack(input bit a, input logic [63:0] rd);
    if (sel64) begin if64.mem_ack = a; if64.mem_rdata = rd; end
    else       begin if32.mem_ack = a; if32.mem_rdata = rd[31:0]; end
  endtask

  task automatic access(input bit w64, input bit we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                        input int unsigned dly, input bit poke);
    bit exc;
    logic [31:0] ea;
    logic [7:0]  ebe;
    logic [63:0] ewd, ed;
    model(w64, we, op, addr, wd, rd, exc, ea, ebe, ewd, ed);
    sel64 = w64;
    #1;
    n_asserts++; if (o_req_ready !== 1'b1) fail("idle_ready", o_req_ready, 1'b1);
    set_req(1'b1, we, op, addr, wd);
    @(negedge clk);
    set_req(1'b0, we, op, addr, wd);
    if (exc) begin
      n_asserts++; if (o_mem_req !== 1'b0) fail("exc_no_memreq", o_mem_req, 1'b0);
      n_asserts++; if (o_resp_valid !== 1'b1) fail("exc_resp_valid", o_resp_valid, 1'b1);
      n_asserts++; if (o_resp_exc !== 1'b1) fail("exc_flag", o_resp_exc, 1'b1);
      n_asserts++; if (o_resp_badaddr !== addr) fail("exc_badaddr", o_resp_badaddr, addr);
      n_asserts++; if (o_resp_data !== 64'h0) fail("exc_data", o_resp_data, 64'h0);
    end else begin
      n_asserts++; if (o_mem_req !== 1'b1) fail("mem_req", o_mem_req, 1'b1);
      n_asserts++; if (o_mem_we !== we) fail("mem_we", o_mem_we, we);
      n_asserts++; if (o_mem_be !== ebe) fail("mem_be", o_mem_be, ebe);
      n_asserts++; if (o_mem_addr !== ea) fail("mem_addr", o_mem_addr, ea);
      n_asserts++; if (o_req_ready !== 1'b0) fail("bus_ready_low", o_req_ready, 1'b0);
      if (we) begin
        n_asserts++; if (o_mem_wdata !== ewd) fail("mem_wdata", o_mem_wdata, ewd);
      end
      for (int unsigned i = 0; i < dly; i++) begin
        if (poke) set_req(1'b1, 1'b0, 3'b100, addr ^ 32'h40, ~wd);
        @(negedge clk);
        n_asserts++; if (o_req_ready !== 1'b0) fail("stall_ready", o_req_ready, 1'b0);
        n_asserts++; if (o_mem_req !== 1'b1) fail("stall_req", o_mem_req, 1'b1);
        n_asserts++; if (o_mem_addr !== ea) fail("stall_addr", o_mem_addr, ea);
        n_asserts++; if (o_mem_be !== ebe) fail("stall_be", o_mem_be, ebe);
        n_asserts++; if (o_resp_valid !== 1'b0) fail("stall_no_resp", o_resp_valid, 1'b0);
        if (we) begin
          n_asserts++; if (o_mem_wdata !== ewd) fail("stall_wdata", o_mem_wdata, ewd);
        end
      end
      set_req(1'b0, 1'b0, 3'b000, 32'h0, 64'h0);
      set_ack(1'b1, rd);
      @(negedge clk);
      set_ack(1'b0, ~rd);
      n_asserts++; if (o_resp_valid !== 1'b1) fail("resp_valid", o_resp_valid, 1'b1);
      n_asserts++; if (o_resp_data !== ed) fail("resp_data", o_resp_data, ed);
      n_asserts++; if (o_resp_exc !== 1'b0) fail("resp_exc", o_resp_exc, 1'b0);
      n_asserts++; if (o_mem_req !== 1'b0) fail("resp_memreq_low", o_mem_req, 1'b0);
    end
    @(negedge clk);
    n_asserts++; if (o_resp_valid !== 1'b0) fail("resp_one_cycle", o_resp_valid, 1'b0);
    n_asserts++; if (o_req_ready !== 1'b1) fail("back_idle", o_req_ready, 1'b1);
    n_asserts++; if (o_mem_req !== 1'b0) fail("idle_memreq", o_mem_req, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if32.req_valid = 0; if32.req_we = 0; if32.req_op = 0; if32.req_addr = 0;
    if32.req_wdata = 0; if32.mem_ack = 0; if32.mem_rdata = 0;
    if64.req_valid = 0; if64.req_we = 0; if64.req_op = 0; if64.req_addr = 0;
    if64.req_wdata = 0; if64.mem_ack = 0; if64.mem_rdata = 0;
    repeat (3) @(negedge clk);
    n_asserts++; if (if32.req_ready !== 1'b1) fail("rst_ready", if32.req_ready, 1'b1);
    n_asserts++; if (if32.mem_req !== 1'b0) fail("rst_memreq", if32.mem_req, 1'b0);
    n_asserts++; if (if32.mem_we !== 1'b0) fail("rst_memwe", if32.mem_we, 1'b0);
    n_asserts++; if (if32.mem_be !== 4'h0) fail("rst_be", if32.mem_be, 4'h0);
    n_asserts++; if (if32.mem_addr !== 32'h0) fail("rst_addr", if32.mem_addr, 32'h0);
    n_asserts++; if (if32.mem_wdata !== 32'h0) fail("rst_wdata", if32.mem_wdata, 32'h0);
    n_asserts++; if (if32.resp_valid !== 1'b0) fail("rst_resp_valid", if32.resp_valid, 1'b0);
    n_asserts++; if (if32.resp_data !== 32'h0) fail("rst_resp_data", if32.resp_data, 32'h0);
    n_asserts++; if (if32.resp_exc !== 1'b0) fail("rst_resp_exc", if32.resp_exc, 1'b0);
    n_asserts++; if (if32.resp_badaddr !== 32'h0) fail("rst_badaddr", if32.resp_badaddr, 32'h0);
    n_asserts++; if (if64.req_ready !== 1'b1) fail("rst64_ready", if64.req_ready, 1'b1);
    n_asserts++; if (if64.mem_be !== 8'h00) fail("rst64_be", if64.mem_be, 8'h00);
    reset_n = 1'b1;
    @(negedge clk);

    access(1'b0, 1'b0, 3'b011, 32'h1003, 64'h0, 64'h80112233, 0, 1'b0);
    access(1'b0, 1'b1, 3'b001, 32'h2002, 64'h0000BEEF, 64'h0, 5, 1'b1);
    access(1'b0, 1'b0, 3'b010, 32'h0000, 64'h0, 64'h1234F00D, 2, 1'b1);
    access(1'b0, 1'b0, 3'b000, 32'h1001, 64'h0, 64'hCAFEBABE, 0, 1'b0);
    access(1'b0, 1'b0, 3'b111, 32'h3002, 64'h0, 64'h8765_4321, 1, 1'b0);
    access(1'b1, 1'b1, 3'b110, 32'h0008, 64'h0123456789ABCDEF, 64'h0, 0, 1'b0);
    access(1'b1, 1'b0, 3'b000, 32'h0004, 64'h0, 64'h80000000_11223344, 0, 1'b0);
    access(1'b1, 1'b0, 3'b101, 32'h0014, 64'h0, 64'h80000000_11223344, 1, 1'b0);

    // Reset while the bus access is outstanding, then a stale ack.
    sel64 = 1'b0;
    #1;
    set_req(1'b1, 1'b0, 3'b000, 32'h0100, 64'h0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 64'h0);
    n_asserts++; if (o_mem_req !== 1'b1) fail("pre_rst_memreq", o_mem_req, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    n_asserts++; if (o_mem_req !== 1'b0) fail("rst_mid_memreq", o_mem_req, 1'b0);
    n_asserts++; if (o_resp_valid !== 1'b0) fail("rst_mid_no_resp", o_resp_valid, 1'b0);
    n_asserts++; if (o_req_ready !== 1'b1) fail("rst_mid_ready", o_req_ready, 1'b1);
    reset_n = 1'b1;
    set_ack(1'b1, 64'hFFFF_FFFF);
    @(negedge clk);
    set_ack(1'b0, 64'h0);
    n_asserts++; if (o_resp_valid !== 1'b0) fail("stale_ack_no_resp", o_resp_valid, 1'b0);
    n_asserts++; if (o_mem_req !== 1'b0) fail("stale_ack_memreq", o_mem_req, 1'b0);
    n_asserts++; if (o_req_ready !== 1'b1) fail("stale_ack_ready", o_req_ready, 1'b1);
    @(negedge clk);
    n_asserts++; if (o_resp_valid !== 1'b0) fail("stale_ack_no_resp2", o_resp_valid, 1'b0);

    for (int k = 0; k < 40; k++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             $urandom, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage access engine for the MIPS pipeline; generalises the MEM-stage control decode (MemWrite plus 3-bit MemOp).
- Accepts one load/store per request from the pipeline and drives a req/ack data-memory bus with byte enables and lane-replicated write data.
- Returns sign/zero-extended load data or store completion, and detects misaligned accesses.
- Parametrised in address width and bus width (32- or 64-bit), so it serves both the current core and a 64-bit data path.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, memory bus width; legal values 32 or 64; NB = DATA_W/8 byte lanes, OFF_W = log2(NB)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
req_valid  in  1  pipeline presents an access
req_ready  out  1  unit can accept (high only in IDLE)
req_we  in  1  MemWrite: 1 = store, 0 = load
req_op  in  3  MemOp: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned, 101 word unsigned / 110 doubleword (DATA_W=64 only)
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_be  out  NB  byte enables
mem_addr  out  ADDR_W  bus address, low OFF_W bits zero
mem_wdata  out  DATA_W  lane-replicated write data
mem_ack  in  1  bus completion, valid only while mem_req=1
mem_rdata  in  DATA_W  read data, valid with mem_ack
resp_valid  out  1  one-cycle completion pulse
resp_data  out  DATA_W  extended load data (0 for stores)
resp_exc  out  1  address-error exception, qualified by resp_valid
resp_badaddr  out  ADDR_W  faulting address, qualified by resp_exc

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE, so req_ready=1. mem_req, mem_we, resp_valid and resp_exc are 0. mem_be, mem_addr, mem_wdata, resp_data and resp_badaddr are 0.
- Reset mid-access: mem_req drops at that edge and the access is abandoned; no resp_valid.
- FSM states: IDLE, BUS, RESP.
- IDLE: on req_valid, the request is registered; next state is BUS, or RESP if misaligned.
- BUS: mem_req=1 and bus outputs are held stable until mem_ack. When mem_ack=1: loads capture mem_rdata, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Throughput: req_ready is low in BUS and RESP.
- Minimum latency: accept at edge T; mem_req high during cycle T+1; earliest ack in T+1; resp_valid in T+2. Back-to-back issue interval is 3 cycles.
- mem_ack while not in BUS is ignored.
- Lane math is little-endian: off = req_addr[OFF_W-1:0]; mem_addr = req_addr with low OFF_W bits cleared.
- Byte access: mem_be = 1<<off; wdata byte replicated across all lanes.
- Half access: be = 2'b11<<off; half replicated.
- Word access: be = 4'hF<<(off & ~3); word replicated.
- Doubleword access: all ones.
- Load extract: lane shifted down by off, then sign- or zero-extended to DATA_W per req_op. Word signed (000) sign-extends on DATA_W=64.
- Illegal op: 101/110/111 with DATA_W=32, or 111 with DATA_W=64, is treated as word (000).
- Stores return resp_valid with resp_data=0 and resp_exc=0.

Optional Feature:
MEM_ALIGN_CHK_EN
- Defined: half requires off[0]=0; word requires off[1:0]=0; doubleword requires off[2:0]=0. A violation skips BUS and mem_req never rises. RESP then pulses with resp_exc=1 and resp_badaddr=req_addr; resp_data=0.
- Undefined: no check. Low offset bits below the access size are forced to zero before lane selection. resp_exc and resp_badaddr are tied 0.

Decomposition:
- Shared package mem_pkg:
  - MemOp encodings as localparams: OP_W, OP_HS, OP_HU, OP_BS, OP_BU, OP_WU, OP_D.
  - FSM state encodings.
  - Helper function computing the byte-enable mask from op and offset.
- One natural combinational sub-module, load_extend: takes rdata, off and op; outputs extended data.

Test Plan:
1. DATA_W=32, load byte signed at addr 0x1003 with mem_rdata=0x80112233. Expect mem_addr=0x1000, mem_be=4'b1000, resp_data=0xFFFFFF80, resp_valid exactly at T+2 with ack in T+1.
2. Store half at addr 0x2002 with req_wdata=0x0000BEEF. Expect mem_be=4'b1100, mem_wdata=0xBEEFBEEF, mem_we=1. Hold mem_ack low for 5 cycles: req_ready stays 0 and bus outputs stay stable.
3. Load half unsigned at 0x0000, rdata=0x1234F00D. Expect resp_data=0x0000F00D. A second req_valid during BUS is not accepted until req_ready returns.
4. With MEM_ALIGN_CHK_EN, load word at 0x1001. Expect mem_req never asserted, resp_exc=1, resp_badaddr=0x1001. Without the macro, expect mem_be=4'hF at 0x1000.
5. DATA_W=64, doubleword store at 0x8. Expect mem_be=8'hFF. Load word signed at offset 4 with upper word 0x80000000: expect resp_data=0xFFFFFFFF80000000.
6. Assert reset_n=0 while in BUS. Expect mem_req=0 next edge and no resp_valid. A stale mem_ack after reset is ignored and req_ready=1.
